div_seq_32: RTL

DIV_SEQ_32 -- requirements
Module: div_seq_32

---
 rtl/div_seq_32.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/div_seq_32.sv
// div_seq_32: sequential restoring divider producing one quotient bit per cycle.
// Signed operands are reduced to magnitudes, divided unsigned, then sign-corrected.
module div_seq_32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ONE_W = DATA_W'(1);
  localparam logic [DATA_W:0]   ONE_X = (DATA_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W:0]     rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [DATA_W-1:0]   quo_o_q, quo_o_d;
  logic [DATA_W-1:0]   rem_o_q, rem_o_d;
  logic                dbz_q, dbz_d;

  logic [DATA_W:0]     shifted;
  logic [DATA_W+1:0]   trial;
  logic                carry;
  logic [DATA_W-1:0]   dvd_abs;
  logic [DATA_W-1:0]   dvs_abs;

  // work_q starts as the dividend magnitude; its MSB feeds the remainder while
  // quotient bits fill in from the bottom, so after 32 shifts it holds the quotient.
  always_comb begin
    shifted = {rem_q[DATA_W-1:0], work_q[DATA_W-1]};
    trial   = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(DATA_W+1){1'b0}}, 1'b1};
    carry   = trial[DATA_W+1];
    dvd_abs = (sgn_q && dvd_q[DATA_W-1]) ? (~dvd_q + ONE_W) : dvd_q;
    dvs_abs = (sgn_q && dvs_q[DATA_W-1]) ? (~dvs_q + ONE_W) : dvs_q;
  end

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    work_d  = work_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quo_o_d = quo_o_q;
    rem_o_d = rem_o_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d   = is_signed;
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = PREP;
        end
      end

      PREP: begin
        work_d  = dvd_abs;
        dvs_d   = dvs_abs;
        q_neg_d = sgn_q & (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1]);
        r_neg_d = sgn_q & dvd_q[DATA_W-1];
        rem_d   = '0;
        cnt_d   = CNT_W'(DATA_W - 1);
        dbz_d   = 1'b0;
        state_d = CALC;
      end

      CALC: begin
        work_d = {work_q[DATA_W-2:0], carry};
        rem_d  = carry ? trial[DATA_W:0] : shifted;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      FIX: begin
        // dvd_q still holds the raw dividend; dvs_q is a magnitude, zero only if divisor was zero
        if (dvs_q == '0) begin
          quo_o_d = '1;
          rem_o_d = dvd_q;
          dbz_d   = 1'b1;
        end else begin
          quo_o_d = q_neg_q ? (~work_q + ONE_W) : work_q;
          rem_o_d = r_neg_q ? DATA_W'(~rem_q + ONE_X) : DATA_W'(rem_q);
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_o_q <= '0;
      rem_o_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quo_o_q <= quo_o_d;
      rem_o_q <= rem_o_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quo_o_q;
  assign remainder   = rem_o_q;
  assign div_by_zero = dbz_q;

endmodule
